// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin icache/dcache line requests serialised into word beats on one memory port
module line_mem_arbiter #(
    parameter int WORDS_PER_LINE = 4,
    parameter bit RESET_PRIO     = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [31:0]                  ic_addr_i,
    input  logic                         ic_req_valid_i,
    output logic                         ic_req_ready_o,
    output logic                         ic_rsp_valid_o,
    input  logic                         ic_rsp_ready_i,
    output logic [32*WORDS_PER_LINE-1:0] ic_rsp_data_o,
    output logic [31:0]                  ic_rsp_addr_o,
    input  logic [31:0]                  dc_addr_i,
    input  logic                         dc_req_valid_i,
    output logic                         dc_req_ready_o,
    input  logic                         dc_we_i,
    input  logic [32*WORDS_PER_LINE-1:0] dc_data_wr_i,
    output logic                         dc_rsp_valid_o,
    input  logic                         dc_rsp_ready_i,
    output logic [32*WORDS_PER_LINE-1:0] dc_rsp_data_o,
    output logic [31:0]                  dc_rsp_addr_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [31:0]                  mem_rdata_i
);
    localparam int LW = 32 * WORDS_PER_LINE;
    localparam int BW = $clog2(WORDS_PER_LINE);
    localparam logic [31:0] LINE_MASK = ~32'(LW / 8 - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            rr_q, rr_d;
    logic            cl_q, cl_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [LW-1:0]   line_q, line_d;
    logic [LW-1:0]   ic_data_q, ic_data_d, dc_data_q, dc_data_d;
    logic [31:0]     ic_addr_q, ic_addr_d, dc_addr_q, dc_addr_d;
    logic            ic_acc, dc_acc;

    // rr_q names the client that wins a same-cycle conflict; a lone requester is always ready
    assign ic_req_ready_o = (state_q == IDLE) && (!dc_req_valid_i || !rr_q);
    assign dc_req_ready_o = (state_q == IDLE) && (!ic_req_valid_i || rr_q);
    assign ic_acc         = ic_req_valid_i && ic_req_ready_o;
    assign dc_acc         = dc_req_valid_i && dc_req_ready_o;
    assign mem_req_o      = state_q == ISSUE;
    assign mem_we_o       = mem_req_o && we_q;
    assign mem_addr_o     = addr_q + 32'({beat_q, 2'b00});
    assign mem_wdata_o    = line_q[{beat_q, 5'b0} +: 32];
    assign ic_rsp_valid_o = (state_q == RESP) && !cl_q;
    assign dc_rsp_valid_o = (state_q == RESP) && cl_q;
    assign ic_rsp_data_o  = ic_data_q;
    assign ic_rsp_addr_o  = ic_addr_q;
    assign dc_rsp_data_o  = dc_data_q;
    assign dc_rsp_addr_o  = dc_addr_q;

    // next-state: accept, issue each beat until granted, collect beat, hand the line to its owner
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rr_d      = rr_q;
        cl_d      = cl_q;
        we_d      = we_q;
        addr_d    = addr_q;
        line_d    = line_q;
        ic_data_d = ic_data_q;
        ic_addr_d = ic_addr_q;
        dc_data_d = dc_data_q;
        dc_addr_d = dc_addr_q;
        case (state_q)
            IDLE: if (ic_acc || dc_acc) begin
                cl_d    = dc_acc;
                we_d    = dc_acc && dc_we_i;
                addr_d  = (dc_acc ? dc_addr_i : ic_addr_i) & LINE_MASK;
                line_d  = dc_acc ? dc_data_wr_i : '0;
                rr_d    = !dc_acc;
                beat_d  = '0;
                state_d = ISSUE;
            end
            ISSUE: state_d = mem_gnt_i ? WAIT : ISSUE;
            WAIT: if (mem_rvalid_i) begin
                if (!we_q) line_d[{beat_q, 5'b0} +: 32] = mem_rdata_i;
                if (beat_q == BW'(WORDS_PER_LINE - 1)) begin
                    beat_d  = '0;
                    state_d = RESP;
                    if (cl_q) begin
                        dc_data_d = line_d;
                        dc_addr_d = addr_q;
                    end else begin
                        ic_data_d = line_d;
                        ic_addr_d = addr_q;
                    end
                end else begin
                    beat_d  = beat_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            RESP: state_d = (cl_q ? dc_rsp_ready_i : ic_rsp_ready_i) ? IDLE : RESP;
        endcase
    end

    // state registers; reset drops any transaction in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            rr_q      <= RESET_PRIO;
            cl_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            line_q    <= '0;
            ic_data_q <= '0;
            ic_addr_q <= '0;
            dc_data_q <= '0;
            dc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rr_q      <= rr_d;
            cl_q      <= cl_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            ic_data_q <= ic_data_d;
            ic_addr_q <= ic_addr_d;
            dc_data_q <= dc_data_d;
            dc_addr_q <= dc_addr_d;
        end
    end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: scoreboard bench with a word-memory model for line_mem_arbiter
module tb_line_mem_arbiter;
    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [31:0]  ic_addr_i, dc_addr_i;
    logic         ic_req_valid_i, ic_req_ready_o, ic_rsp_valid_o, ic_rsp_ready_i;
    logic [127:0] ic_rsp_data_o, dc_data_wr_i, dc_rsp_data_o;
    logic [31:0]  ic_rsp_addr_o, dc_rsp_addr_o;
    logic         dc_req_valid_i, dc_req_ready_o, dc_we_i, dc_rsp_valid_o, dc_rsp_ready_i;
    logic         mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;

    typedef struct packed {logic cl; logic [31:0] addr; logic [127:0] data;} rsp_t;

    rsp_t        exp_q[$], obs_q[$];
    logic        order_q[$];
    logic [31:0] log_addr[$], log_wd[$];
    logic        log_we[$];
    logic [31:0] mem[logic [31:0]];
    int          gnt_dly[4], rv_dly[4];
    int          errors = 0, checks = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0;
    int          ic_done = 0, dc_done = 0, unstable = 0, stalls = 0;
    logic        rv_prev = 1'b0;

    line_mem_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .ic_addr_i(ic_addr_i), .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_ready_i(ic_rsp_ready_i),
        .ic_rsp_data_o(ic_rsp_data_o), .ic_rsp_addr_o(ic_rsp_addr_o),
        .dc_addr_i(dc_addr_i), .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_we_i(dc_we_i), .dc_data_wr_i(dc_data_wr_i),
        .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_ready_i(dc_rsp_ready_i),
        .dc_rsp_data_o(dc_rsp_data_o), .dc_rsp_addr_o(dc_rsp_addr_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [127:0] rd_line(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = rd(a + 32'(4 * k));
        return l;
    endfunction

    // memory model: grants after gnt_dly[beat] waiting cycles, returns rvalid rv_dly[beat] cycles later
    initial begin
        logic        cnt_on, pend, s_we;
        int          g_cnt, r_cnt;
        logic [31:0] pend_d, s_addr, s_wd;
        cnt_on = 0; pend = 0; g_cnt = 0; r_cnt = 0; s_we = 0; pend_d = 0; s_addr = 0; s_wd = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i = 0;
            mem_rvalid_i = 0;
            if (pend) begin
                if (r_cnt == 0) begin
                    mem_rvalid_i = 1; mem_rdata_i = pend_d; pend = 0;
                end else r_cnt--;
            end else if (mem_req_o) begin
                if (!cnt_on) begin
                    cnt_on = 1; g_cnt = gnt_dly[mem_addr_o[3:2]];
                    s_addr = mem_addr_o; s_wd = mem_wdata_o; s_we = mem_we_o;
                end else if (mem_addr_o !== s_addr || mem_wdata_o !== s_wd || mem_we_o !== s_we) unstable++;
                if (g_cnt == 0) begin
                    mem_gnt_i = 1; cnt_on = 0;
                    log_addr.push_back(mem_addr_o); log_we.push_back(mem_we_o); log_wd.push_back(mem_wdata_o);
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    pend_d = mem_we_o ? 32'h0 : rd(mem_addr_o);
                    pend = 1; r_cnt = rv_dly[mem_addr_o[3:2]];
                end else begin
                    g_cnt--; stalls++;
                end
            end else if (cnt_on) begin
                unstable++; cnt_on = 0;
            end
        end
    end

    // response monitor: a handshake seen at a negedge completes on the following posedge
    always @(negedge clk_i) begin
        if (ic_rsp_valid_o && ic_rsp_ready_i) begin
            obs_q.push_back(rsp_t'{1'b0, ic_rsp_addr_o, ic_rsp_data_o}); ic_done++;
        end
        if (dc_rsp_valid_o && dc_rsp_ready_i) begin
            obs_q.push_back(rsp_t'{1'b1, dc_rsp_addr_o, dc_rsp_data_o}); dc_done++;
        end
        if ((ic_rsp_valid_o || dc_rsp_valid_o) && !rv_prev) rsp_cyc = cyc;
        rv_prev = ic_rsp_valid_o || dc_rsp_valid_o;
    end

    task automatic drive(input logic cl, input logic we, input logic [31:0] a,
                         input logic [127:0] d, input logic [127:0] exp_data);
        int n;
        if (cl) begin
            dc_addr_i = a; dc_we_i = we; dc_data_wr_i = d; dc_req_valid_i = 1;
        end else begin
            ic_addr_i = a; ic_req_valid_i = 1;
        end
        n = 0;
        do begin
            @(negedge clk_i); n++;
        end while (!(cl ? dc_req_ready_o : ic_req_ready_o) && n < 300);
        checks++;
        if (!(cl ? dc_req_ready_o : ic_req_ready_o)) begin
            errors++; $display("FAIL accept client=%0d got ready=0 need ready=1", cl);
        end else begin
            acc_cyc = cyc;
            exp_q.push_back(rsp_t'{cl, a & ~32'hF, exp_data});
            order_q.push_back(cl);
        end
        @(posedge clk_i); #1;
        if (cl) dc_req_valid_i = 0; else ic_req_valid_i = 0;
    endtask

    task automatic get_rsp(output rsp_t e, output rsp_t o);
        for (int n = 0; n < 500 && obs_q.size() == 0; n++) @(negedge clk_i);
        e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
        o = obs_q.size() != 0 ? obs_q.pop_front() : 'x;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1 rstn_i = 0;
        @(posedge clk_i); #1 rstn_i = 1;
    endtask

    task automatic test_reset();
        ic_req_valid_i = 1; dc_req_valid_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            errors++; $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h need all 0", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        checks++;
        if ({ic_rsp_valid_o, dc_rsp_valid_o, ic_rsp_data_o, ic_rsp_addr_o, dc_rsp_data_o, dc_rsp_addr_o} !== '0) begin
            errors++; $display("FAIL reset_rsp got ic_v=%b dc_v=%b ic_a=%h dc_a=%h need all 0", ic_rsp_valid_o, dc_rsp_valid_o, ic_rsp_addr_o, dc_rsp_addr_o);
        end
        checks++;
        if ({ic_req_ready_o, dc_req_ready_o} !== 2'b01) begin
            errors++; $display("FAIL reset_prio got ic_rdy=%b dc_rdy=%b need 0 1", ic_req_ready_o, dc_req_ready_o);
        end
        ic_req_valid_i = 0; dc_req_valid_i = 0;
        @(posedge clk_i); #1 rstn_i = 1;
    endtask

    task automatic test_fill();
        rsp_t e, o;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        for (int k = 0; k < 4; k++) mem[32'h1230 + 32'(4 * k)] = 32'hA0 + 32'(k);
        @(posedge clk_i); #1;
        drive(1, 0, 32'h0000_1234, '0, 128'h000000A3_000000A2_000000A1_000000A0);
        get_rsp(e, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL fill_rsp got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", o.cl, o.addr, o.data, e.cl, e.addr, e.data);
        end
        checks++;
        if (rsp_cyc - acc_cyc !== 9) begin
            errors++; $display("FAIL fill_latency got %0d cycles need 9", rsp_cyc - acc_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_addr[k] !== 32'h1230 + 32'(4 * k) || log_we[k] !== 1'b0) begin
                errors++; $display("FAIL fill_beat%0d got addr=%h we=%b need addr=%h we=0", k, log_addr[k], log_we[k], 32'h1230 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_writeback();
        rsp_t e, o;
        logic [127:0] line;
        line = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        @(posedge clk_i); #1;
        drive(1, 1, 32'h0000_2000, line, line);
        get_rsp(e, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL wb_rsp got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", o.cl, o.addr, o.data, e.cl, e.addr, e.data);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_addr[k] !== 32'h2000 + 32'(4 * k) || log_we[k] !== 1'b1 || log_wd[k] !== line[32*k +: 32]) begin
                errors++; $display("FAIL wb_beat%0d got addr=%h we=%b wdata=%h need addr=%h we=1 wdata=%h", k, log_addr[k], log_we[k], log_wd[k], 32'h2000 + 32'(4 * k), line[32*k +: 32]);
            end
        end
    endtask

    task automatic test_round_robin();
        rsp_t e, o;
        logic [3:0] ord;
        do_reset();
        order_q.delete();
        @(posedge clk_i); #1;
        fork
            for (int k = 0; k < 2; k++) begin
                int d0;
                logic [31:0] a;
                d0 = dc_done; a = 32'h8000 + 32'(16 * k);
                drive(1, 0, a, '0, rd_line(a));
                for (int n = 0; n < 300 && dc_done == d0; n++) @(negedge clk_i);
                @(posedge clk_i); #1;
            end
            for (int k = 0; k < 2; k++) begin
                int i0;
                logic [31:0] a;
                i0 = ic_done; a = 32'h9000 + 32'(64 * k);
                drive(0, 0, a, '0, rd_line(a));
                for (int n = 0; n < 300 && ic_done == i0; n++) @(negedge clk_i);
                @(posedge clk_i); #1;
            end
        join
        for (int k = 0; k < 4; k++) begin
            get_rsp(e, o);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL rr_rsp%0d got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", k, o.cl, o.addr, o.data, e.cl, e.addr, e.data);
            end
        end
        ord = {order_q[0], order_q[1], order_q[2], order_q[3]};
        checks++;
        if (ord !== 4'b1010) begin
            errors++; $display("FAIL rr_order got %b need 1010 (1=dcache)", ord);
        end
    endtask

    task automatic test_stall();
        rsp_t e, o;
        logic [127:0] w;
        w = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
        gnt_dly[2] = 3; rv_dly[2] = 4; unstable = 0; stalls = 0;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        @(posedge clk_i); #1;
        drive(1, 1, 32'h0000_7000, w, w);
        get_rsp(e, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL stall_wr got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", o.cl, o.addr, o.data, e.cl, e.addr, e.data);
        end
        @(posedge clk_i); #1;
        drive(0, 0, 32'h0000_7004, '0, w);
        get_rsp(e, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL stall_rd got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", o.cl, o.addr, o.data, e.cl, e.addr, e.data);
        end
        checks++;
        if (unstable !== 0 || stalls !== 6) begin
            errors++; $display("FAIL stall_hold got unstable=%0d stalls=%0d need unstable=0 stalls=6", unstable, stalls);
        end
        checks++;
        if (log_addr[2] !== 32'h7008 || log_wd[2] !== w[95:64]) begin
            errors++; $display("FAIL stall_beat2 got addr=%h wdata=%h need addr=00007008 wdata=%h", log_addr[2], log_wd[2], w[95:64]);
        end
        gnt_dly[2] = 0; rv_dly[2] = 0;
    endtask

    task automatic test_rsp_hold();
        rsp_t e, o;
        logic [3:0] held;
        held = 0;
        dc_rsp_ready_i = 0;
        order_q.delete();
        @(posedge clk_i); #1;
        drive(1, 0, 32'h0000_5000, '0, rd_line(32'h5000));
        for (int n = 0; n < 300 && !dc_rsp_valid_o; n++) @(negedge clk_i);
        fork
            begin
                @(posedge clk_i); #1;
                drive(0, 0, 32'h0000_6000, '0, rd_line(32'h6000));
            end
            begin
                @(posedge clk_i); #1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk_i);
                    checks++;
                    if (dc_rsp_valid_o !== 1'b1 || dc_rsp_data_o !== exp_q[0].data || dc_rsp_addr_o !== 32'h5000 || ic_req_ready_o !== 1'b0) begin
                        errors++; $display("FAIL hold%0d got v=%b addr=%h ic_rdy=%b data=%h need v=1 addr=00005000 ic_rdy=0 data=%h", k, dc_rsp_valid_o, dc_rsp_addr_o, ic_req_ready_o, dc_rsp_data_o, exp_q[0].data);
                    end
                    held++;
                end
                @(posedge clk_i); #1 dc_rsp_ready_i = 1;
            end
        join
        for (int k = 0; k < 2; k++) begin
            get_rsp(e, o);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL hold_rsp%0d got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", k, o.cl, o.addr, o.data, e.cl, e.addr, e.data);
            end
        end
        checks++;
        if (held !== 4'd5 || order_q.size() !== 2 || order_q[0] !== 1'b1) begin
            errors++; $display("FAIL hold_order got held=%0d accepts=%0d need held=5 accepts=2 dcache first", held, order_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rsp_t e, o;
        logic bad;
        bad = 0;
        rv_dly[1] = 4;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        @(posedge clk_i); #1;
        drive(1, 0, 32'h0000_3000, '0, rd_line(32'h3000));
        void'(exp_q.pop_back());
        for (int n = 0; n < 100 && log_addr.size() < 2; n++) @(posedge clk_i);
        #1 rstn_i = 0;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ic_rsp_valid_o, dc_rsp_valid_o, dc_rsp_data_o, dc_rsp_addr_o} !== '0) begin
            errors++; $display("FAIL midreset_out got req=%b addr=%h dc_v=%b dc_a=%h need all 0", mem_req_o, mem_addr_o, dc_rsp_valid_o, dc_rsp_addr_o);
        end
        @(posedge clk_i); #1 rstn_i = 1;
        repeat (8) begin
            @(negedge clk_i);
            if (mem_req_o || ic_rsp_valid_o || dc_rsp_valid_o) bad = 1;
        end
        checks++;
        if (bad !== 1'b0 || obs_q.size() !== 0) begin
            errors++; $display("FAIL midreset_quiet got activity=%b responses=%0d need 0 0", bad, obs_q.size());
        end
        rv_dly[1] = 0;
        @(posedge clk_i); #1;
        drive(1, 0, 32'h0000_4000, '0, rd_line(32'h4000));
        get_rsp(e, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL midreset_next got cl=%0d addr=%h data=%h need cl=%0d addr=%h data=%h", o.cl, o.addr, o.data, e.cl, e.addr, e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            gnt_dly[k] = 0; rv_dly[k] = 0;
        end
        rstn_i = 0;
        ic_addr_i = 0; ic_req_valid_i = 0; ic_rsp_ready_i = 1;
        dc_addr_i = 0; dc_req_valid_i = 0; dc_we_i = 0; dc_data_wr_i = 0; dc_rsp_ready_i = 1;
        test_reset();
        test_fill();
        test_writeback();
        test_round_robin();
        test_stall();
        test_rsp_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
